// File: rtl/fetch_unit.sv
// fetch_unit: PC register, redirect handling and the IF/ID pipeline register.
// Optional sentinel halt detection is compiled in with FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_address,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        sentinel_hit;

  // 32-bit add wraps naturally from FFFFFFFC to 0
  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_HALT_DETECT_EN
  assign sentinel_hit = (instr_in == '1);
`else
  assign sentinel_hit = 1'b0;
`endif

  // State register; reset overrides every other request in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  // Next-state: branch > jump > halted hold > stall > sentinel > advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (branch_taken) begin
      // Masking keeps the target word-aligned
      pc_d    = branch_target & 32'hFFFF_FFFC;
      instr_d = '0;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (jump) begin
      // Region bits come from the PC+4 of the jump sitting in IF/ID
      pc_d    = {pc_plus4_q[31:28], jump_index, 2'b00};
      instr_d = '0;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      valid_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (sentinel_hit) begin
      state_d = ST_HALTED;
      instr_d = '0;
      valid_d = 1'b0;
    end else begin
      pc_d       = pc_plus4;
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    pc_address     = pc_q;
    if_id_instr    = instr_q;
    if_id_pc_plus4 = pc_plus4_q;
    if_id_valid    = valid_q;
    fetch_count    = count_q;
`ifdef FETCH_HALT_DETECT_EN
    halted         = (state_q == ST_HALTED);
`else
    halted         = 1'b0;
`endif
  end

endmodule
